// File: rtl/id_stage_if.sv
// Fetch-side handshake, write-back port and decoded bundle toward the ID/EX register.
interface id_stage_if #(
  parameter int WIDTH = 16
);
  logic             if_valid;
  logic [WIDTH-1:0] if_ir;
  logic [WIDTH-1:0] if_pc;
  logic             if_ready;
  logic             flush;
  logic             ex_ready;
  logic             ex_valid;
  logic             ex_is_load;
  logic [2:0]       ex_dest;
  logic             wb_en;
  logic [2:0]       wb_dest;
  logic [WIDTH-1:0] wb_data;
  logic             id_valid;
  logic [WIDTH-1:0] PC_out;
  logic [WIDTH-1:0] SR1_out;
  logic [WIDTH-1:0] SR2_out;
  logic [WIDTH-1:0] imm4_out;
  logic [WIDTH-1:0] imm5_out;
  logic [WIDTH-1:0] adj6_out;
  logic [WIDTH-1:0] adj9_out;
  logic [WIDTH-1:0] adj11_out;
  logic [WIDTH-1:0] offset6_out;
  logic [WIDTH-1:0] trapvect8_out;
  logic [2:0]       dest_out;
  logic             dest_we;
  logic [3:0]       opcode_out;
  logic [WIDTH-1:0] stall_count;

  modport master (
    output if_valid, if_ir, if_pc, flush, ex_ready, ex_valid, ex_is_load, ex_dest,
           wb_en, wb_dest, wb_data,
    input  if_ready, id_valid, PC_out, SR1_out, SR2_out, imm4_out, imm5_out, adj6_out,
           adj9_out, adj11_out, offset6_out, trapvect8_out, dest_out, dest_we,
           opcode_out, stall_count
  );

  modport slave (
    input  if_valid, if_ir, if_pc, flush, ex_ready, ex_valid, ex_is_load, ex_dest,
           wb_en, wb_dest, wb_data,
    output if_ready, id_valid, PC_out, SR1_out, SR2_out, imm4_out, imm5_out, adj6_out,
           adj9_out, adj11_out, offset6_out, trapvect8_out, dest_out, dest_we,
           opcode_out, stall_count
  );
endinterface

// File: rtl/id_stage.sv
// LC-3b decode stage: IF/ID latch, 8x16 register file with write-back bypass,
// immediate generation, destination decode and load-use hazard stall.
module id_stage #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input logic         clk,
  input logic         rst_n,
  id_stage_if.slave   bus
);

  typedef enum logic [3:0] {
    OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB  = 4'h3,
    OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR  = 4'h7,
    OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI  = 4'hB,
    OP_JMP = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
  } opcode_e;

  logic [WIDTH-1:0] ir_q, pc_q, stall_count_q;
  logic             valid_q;
  logic [WIDTH-1:0] rf_q [NREGS];

  opcode_e    op;
  logic [2:0] sr1_addr, sr2_addr, dest;
  logic       use1, use2, writes_dest;
  logic       stall, fire, if_ready;

  assign op       = opcode_e'(ir_q[15:12]);
  assign sr1_addr = ir_q[8:6];

  // Source usage, second-source address and destination decode
  always_comb begin
    use1        = 1'b0;
    use2        = 1'b0;
    sr2_addr    = ir_q[2:0];
    dest        = ir_q[11:9];
    writes_dest = 1'b0;
    case (op)
      OP_ADD, OP_AND: begin
        use1        = 1'b1;
        use2        = ~ir_q[5];
        writes_dest = 1'b1;
      end
      OP_NOT, OP_SHF, OP_LDB, OP_LDI, OP_LDR: begin
        use1        = 1'b1;
        writes_dest = 1'b1;
      end
      OP_STB, OP_STI, OP_STR: begin
        use1     = 1'b1;
        use2     = 1'b1;
        sr2_addr = ir_q[11:9];
      end
      OP_JMP: use1 = 1'b1;
      OP_JSR: begin
        use1        = ~ir_q[11];
        dest        = 3'b111;
        writes_dest = 1'b1;
      end
      OP_TRAP: begin
        dest        = 3'b111;
        writes_dest = 1'b1;
      end
      OP_LEA: writes_dest = 1'b1;
      default: ;
    endcase
  end

  assign stall = valid_q & bus.ex_valid & bus.ex_is_load &
                 ((use1 & (bus.ex_dest == sr1_addr)) | (use2 & (bus.ex_dest == sr2_addr)));
  assign fire     = valid_q & ~stall & bus.ex_ready;
  assign if_ready = ~valid_q | fire;

  // IF/ID latch: flush wins over capture, capture wins over drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q    <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (bus.if_valid && if_ready) begin
      ir_q    <= bus.if_ir;
      pc_q    <= bus.if_pc;
      valid_q <= 1'b1;
    end else if (fire) begin
      valid_q <= 1'b0;
    end
  end

  // Register file write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (bus.wb_en) begin
      rf_q[bus.wb_dest] <= bus.wb_data;
    end
  end

  // Saturating load-use stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (stall && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign bus.SR1_out = (bus.wb_en && bus.wb_dest == sr1_addr) ? bus.wb_data : rf_q[sr1_addr];
  assign bus.SR2_out = (bus.wb_en && bus.wb_dest == sr2_addr) ? bus.wb_data : rf_q[sr2_addr];

  assign bus.imm4_out      = {{(WIDTH-4){1'b0}}, ir_q[3:0]};
  assign bus.imm5_out      = {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]};
  assign bus.offset6_out   = {{(WIDTH-6){ir_q[5]}}, ir_q[5:0]};
  assign bus.adj6_out      = {{(WIDTH-7){ir_q[5]}}, ir_q[5:0], 1'b0};
  assign bus.adj9_out      = {{(WIDTH-10){ir_q[8]}}, ir_q[8:0], 1'b0};
  assign bus.adj11_out     = {{(WIDTH-12){ir_q[10]}}, ir_q[10:0], 1'b0};
  assign bus.trapvect8_out = {{(WIDTH-9){1'b0}}, ir_q[7:0], 1'b0};

  assign bus.id_valid    = valid_q & ~stall;
  assign bus.if_ready    = if_ready;
  assign bus.PC_out      = pc_q;
  assign bus.opcode_out  = ir_q[15:12];
  assign bus.dest_out    = dest;
  assign bus.dest_we     = writes_dest & valid_q & ~stall;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, bypass, immediates, load-use stalls,
// back-pressure and flush.
module tb_id_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  id_stage_if #(.WIDTH(16)) bus ();

  id_stage #(.WIDTH(16), .NREGS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] d, input logic [15:0] v);
    bus.wb_en   = 1'b1;
    bus.wb_dest = d;
    bus.wb_data = v;
    step();
    bus.wb_en   = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ir, input logic [15:0] pc);
    bus.if_valid = 1'b1;
    bus.if_ir    = ir;
    bus.if_pc    = pc;
    step();
    bus.if_valid = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.if_valid = 0; bus.if_ir = '0; bus.if_pc = '0; bus.flush = 0;
    bus.ex_ready = 1; bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_dest = '0;
    bus.wb_en = 0; bus.wb_dest = '0; bus.wb_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_id_valid", 16'(bus.id_valid), 16'h0);
    check("rst_if_ready", 16'(bus.if_ready), 16'h1);
    check("rst_dest_we", 16'(bus.dest_we), 16'h0);
    check("rst_pc", bus.PC_out, 16'h0);
    check("rst_sr1", bus.SR1_out, 16'h0);
    check("rst_stall_cnt", bus.stall_count, 16'h0);
    #10 rst_n = 1'b1;
    step();

    wb_write(3'd3, 16'h1234);
    wb_write(3'd2, 16'hAAAA);
    wb_write(3'd5, 16'h0005);
    wb_write(3'd6, 16'h6666);
    wb_write(3'd1, 16'h1111);

    // ADD R1,R3,R3
    issue(16'h12C3, 16'h3000);
    check("add_valid", 16'(bus.id_valid), 16'h1);
    check("add_sr1", bus.SR1_out, 16'h1234);
    check("add_sr2", bus.SR2_out, 16'h1234);
    check("add_dest", 16'(bus.dest_out), 16'h1);
    check("add_dest_we", 16'(bus.dest_we), 16'h1);
    check("add_pc", bus.PC_out, 16'h3000);
    check("add_opcode", 16'(bus.opcode_out), 16'h1);
    // same-cycle write-back of r3 is bypassed onto both operands
    bus.wb_en = 1'b1; bus.wb_dest = 3'd3; bus.wb_data = 16'hBEEF;
    #1;
    check("bypass_sr1", bus.SR1_out, 16'hBEEF);
    check("bypass_sr2", bus.SR2_out, 16'hBEEF);
    step();
    bus.wb_en = 1'b0;

    // immediates
    issue(16'h0FFF, 16'h3002);
    check("br_adj9", bus.adj9_out, 16'hFFFE);
    check("br_dest_we", 16'(bus.dest_we), 16'h0);
    issue(16'h4FFF, 16'h3004);
    check("jsr_adj11", bus.adj11_out, 16'hFFFE);
    check("jsr_dest", 16'(bus.dest_out), 16'h7);
    check("jsr_dest_we", 16'(bus.dest_we), 16'h1);
    issue(16'hF025, 16'h3006);
    check("trap_vect", bus.trapvect8_out, 16'h004A);
    check("trap_dest", 16'(bus.dest_out), 16'h7);
    issue(16'h6E3F, 16'h3008);
    check("ldr_offset6", bus.offset6_out, 16'hFFFF);
    check("ldr_adj6", bus.adj6_out, 16'hFFFE);
    check("ldr_imm4", bus.imm4_out, 16'h000F);
    check("ldr_imm5", bus.imm5_out, 16'hFFFF);
    check("ldr_dest", 16'(bus.dest_out), 16'h7);

    // load-use: ADD R4,R2,R5 behind LDR into R2
    issue(16'h1885, 16'h3010);
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_dest = 3'd2;
    #1;
    check("lu_id_valid", 16'(bus.id_valid), 16'h0);
    check("lu_if_ready", 16'(bus.if_ready), 16'h0);
    check("lu_dest_we", 16'(bus.dest_we), 16'h0);
    check("lu_cnt0", bus.stall_count, 16'h0);
    step();
    bus.ex_valid = 1'b0;
    #1;
    check("lu_cnt1", bus.stall_count, 16'h1);
    check("lu_released", 16'(bus.id_valid), 16'h1);
    check("lu_sr1", bus.SR1_out, 16'hAAAA);
    check("lu_sr2", bus.SR2_out, 16'h0005);
    check("lu_dest", 16'(bus.dest_out), 16'h4);
    step();

    // ADD R4,R1,#2 does not read R2
    issue(16'h1862, 16'h3012);
    bus.ex_valid = 1'b1; bus.ex_dest = 3'd2;
    #1;
    check("nh_id_valid", 16'(bus.id_valid), 16'h1);
    check("nh_if_ready", 16'(bus.if_ready), 16'h1);
    check("nh_sr1", bus.SR1_out, 16'h1111);
    check("nh_imm5", bus.imm5_out, 16'h0002);
    step();
    check("nh_cnt", bus.stall_count, 16'h1);
    bus.ex_valid = 1'b0;

    // STR R6,R1,#0 behind load into R6
    issue(16'h7C40, 16'h3014);
    bus.ex_valid = 1'b1; bus.ex_dest = 3'd6;
    #1;
    check("st_id_valid", 16'(bus.id_valid), 16'h0);
    check("st_if_ready", 16'(bus.if_ready), 16'h0);
    step();
    bus.ex_valid = 1'b0;
    #1;
    check("st_cnt", bus.stall_count, 16'h2);
    check("st_released", 16'(bus.id_valid), 16'h1);
    check("st_sr2", bus.SR2_out, 16'h6666);
    check("st_sr1", bus.SR1_out, 16'h1111);
    check("st_dest", 16'(bus.dest_out), 16'h6);
    check("st_dest_we", 16'(bus.dest_we), 16'h0);
    step();

    // back-pressure then flush with a competing fetch
    issue(16'h12C3, 16'h4000);
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1; bus.if_ir = 16'h1885; bus.if_pc = 16'h5000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_if_ready", 16'(bus.if_ready), 16'h0);
      check("bp_pc", bus.PC_out, 16'h4000);
      check("bp_id_valid", 16'(bus.id_valid), 16'h1);
      step();
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.if_valid = 1'b0;
    #1;
    check("fl_id_valid", 16'(bus.id_valid), 16'h0);
    check("fl_if_ready", 16'(bus.if_ready), 16'h1);
    check("fl_pc", bus.PC_out, 16'h4000);
    check("fl_opcode", 16'(bus.opcode_out), 16'h1);

    // asynchronous reset in the middle of a stall
    bus.ex_ready = 1'b1;
    issue(16'h1885, 16'h6000);
    bus.ex_valid = 1'b1; bus.ex_dest = 3'd2;
    step();
    check("mr_cnt", bus.stall_count, 16'h3);
    rst_n = 1'b0;
    #1;
    check("mr_id_valid", 16'(bus.id_valid), 16'h0);
    check("mr_if_ready", 16'(bus.if_ready), 16'h1);
    check("mr_cnt0", bus.stall_count, 16'h0);
    check("mr_pc", bus.PC_out, 16'h0);
    check("mr_sr1", bus.SR1_out, 16'h0);
    check("mr_opcode", 16'(bus.opcode_out), 16'h0);
    #2 rst_n = 1'b1;
    step();
    check("mr_after", 16'(bus.id_valid), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the LC-3b pipeline, directly upstream of the ID/EX pipeline register. It latches the fetched instruction and PC (the IF/ID latch), holds the 8×16 register file, and reads operands with write-back bypass. It produces the sign-extended and shifted immediate fields and the destination register. It also detects load-use hazards, inserting bubbles and back-pressuring fetch, and presents a valid-qualified bundle that the ID/EX register loads.

## Interface
Parameters:
- WIDTH, 16, datapath / instruction width
- NREGS, 8, register-file depth (address width fixed at 3)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents an instruction
- if_ir  in  16  fetched instruction
- if_pc  in  16  PC of fetched instruction (already incremented)
- if_ready  out  1  stage can accept an instruction this cycle
- flush  in  1  discard held instruction (redirect)
- ex_ready  in  1  ID/EX register loads this cycle
- ex_valid, ex_is_load  in  1 each  instruction now in EX is valid / is LDB, LDI or LDR
- ex_dest  in  3  destination of instruction in EX
- wb_en  in  1  register-file write enable
- wb_dest  in  3  write address
- wb_data  in  16  write data
- id_valid  out  1  bundle below is a real instruction (0 = bubble)
- PC_out, SR1_out, SR2_out  out  16 each  latched PC and operand values
- imm4_out, imm5_out, adj6_out, adj9_out, adj11_out, offset6_out, trapvect8_out  out  16 each  immediates
- dest_out  out  3  destination register
- dest_we  out  1  instruction writes dest_out
- opcode_out  out  4  IR[15:12]
- stall_count  out  16  saturating count of load-use stall cycles

## Operation
- State: IR_q, PC_q, valid_q, regfile r0–r7, stall_count.
- Hazard: `stall = valid_q & ex_valid & ex_is_load & ((use1 & ex_dest==sr1_addr) | (use2 & ex_dest==sr2_addr))`.
- Handoff signals:
  - `fire = valid_q & ~stall & ex_ready`
  - `if_ready = ~valid_q | fire`
  - `id_valid = valid_q & ~stall`
- Capture: if flush, valid_q←0 and no capture. Otherwise, if if_valid & if_ready: IR_q←if_ir, PC_q←if_pc, valid_q←1. Otherwise, if fire: valid_q←0. Otherwise hold.
- Source addresses:
  - sr1_addr = IR[8:6]. use1 for ADD, AND, NOT, JMP, JSRR (JSR with IR[11]=0), SHF, LDB, LDI, LDR, STB, STI, STR.
  - sr2_addr = IR[11:9] for STB/STI/STR, else IR[2:0]. use2 for ADD/AND with IR[5]=0, and for the three stores.
- Dest: IR[11:9] with dest_we=1 for ADD, AND, NOT, SHF, LDB, LDI, LDR, LEA. 3'b111 with dest_we=1 for JSR/JSRR/TRAP. Else dest_out=IR[11:9] with dest_we=0. dest_we is forced to 0 when id_valid=0.
- Operand read: combinational. If wb_en & wb_dest==addr, output wb_data (bypass), else regfile[addr].
- Write: on a clock edge with wb_en, regfile[wb_dest]←wb_data. r0 is an ordinary register.
- Immediates (pure functions of IR_q):
  - imm4 = zext(IR[3:0])
  - imm5 = sext(IR[4:0])
  - offset6 = sext(IR[5:0])
  - adj6 = sext(IR[5:0])<<1
  - adj9 = sext(IR[8:0])<<1
  - adj11 = sext(IR[10:0])<<1
  - trapvect8 = zext(IR[7:0])<<1
- PC_out = PC_q. opcode_out = IR_q[15:12].
- stall_count increments by 1 on each edge where stall=1 and holds at 16'hFFFF.
- Flush during stall: the instruction is dropped and the stall ends next cycle.
- Reset (any time, asynchronous):
  - IR_q, PC_q, all registers, and stall_count go to 0; valid_q goes to 0.
  - Outputs are therefore id_valid=0, dest_we=0, if_ready=1, and all 16-bit outputs 0.
  - Reset mid-stall discards the held instruction.

## Timing
- Decode latency: one cycle. An instruction accepted at edge N appears on the outputs, with id_valid=1, in the cycle after N when not stalled.
- All outputs are combinational from registered state plus the wb bypass and hazard inputs. There is no output register; the ID/EX register provides it.
- Throughput: one instruction per cycle when ex_ready=1 and there are no hazards.
- Load-use: exactly one bubble per dependent load, assuming EX advances the load on the next edge. The stall persists for as long as the matching load remains in EX.
- The if_ready dependence on ex_ready is combinational. Fetch must not make if_valid depend on if_ready.
- Simultaneous write-back and read of the same register returns the new data in the same cycle.

## Test plan
- Reset: assert rst_n=0 mid-stream → all outputs 0, if_ready=1, id_valid=0 immediately, without waiting for a clock edge. Release, then write r3=16'h1234 via wb and issue ADD R1,R3,R3 (16'h12C3) → SR1_out=SR2_out=16'h1234, dest_out=1, dest_we=1.
- Immediates: IR=16'h0FFF (BR nzp, all-ones offset) → adj9=16'hFFFE. IR=16'h4FFF (JSR) → adj11=16'hFFFE, dest_out=7. IR=16'hF025 (TRAP x25) → trapvect8=16'h004A. IR=16'h6E3F (LDR R7,R0,#-1) → offset6=16'hFFFF, adj6=16'hFFFE.
- Load-use: EX holds LDR into R2 (ex_valid=1, ex_is_load=1, ex_dest=2); ID holds ADD R4,R2,R5 → id_valid=0, if_ready=0 for one cycle, stall_count 0→1. Next cycle ex_valid=0 → id_valid=1.
- No false hazard: EX load to R2 with ID holding ADD R4,R1,#2 (IR[5]=1, IR[2:0]=2) → no stall.
- Store source: ID holds STR R6,R1,#0 with an EX load to R6 → stall. Once the stall clears, SR2_out = value of r6.
- Back-pressure and flush: ex_ready=0 for 3 cycles → IR_q held, if_ready=0. flush with if_valid=1 in the same cycle → valid_q=0, incoming instruction not captured.
